rip_ro_freq_counter: RTL and testbench



---
 rtl/rip_ro_freq_counter.sv | 137 +++++++++++++
 tb/tb_rip_ro_freq_counter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rip_ro_freq_counter.sv
// Ring-oscillator frequency counter: synchronises ro, counts its rising edges over a window of WINDOW_CYCLES clk cycles.
// Latency: the result is valid WINDOW_CYCLES cycles after the start edge; ro edges reach the counter SYNC_STAGES+1 cycles late.
// Backpressure: the result is held in HOLD, with valid_o high, until ready_i; no new window starts before that.
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   ro                - raw oscillator net, asynchronous to clk
//   start             - begins one measurement (sampled only in IDLE)
//   continuous        - re-arm automatically on each accepted result (sampled at the handshake)
//   busy              - FSM not idle
//   count_o/overflow_o- last window's edge count and its saturation flag
//   valid_o/ready_i   - result handshake
module rip_ro_freq_counter #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int COUNT_W       = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ro,
  input  logic               start,
  input  logic               continuous,
  output logic               busy,
  output logic [COUNT_W-1:0] count_o,
  output logic               overflow_o,
  output logic               valid_o,
  input  logic               ready_i
);

  // The window counter only has to hold WINDOW_CYCLES-1. It is at least 1 bit wide so that a window of one cycle still works.
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0]   WIN_LOAD = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 ro_prev_q;
  logic                 ro_s;
  logic                 rise;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d, cnt_step;
  logic                 sat_q, sat_d, sat_step;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;

  assign ro_s = sync_q[SYNC_STAGES-1];
  assign rise = ro_s & ~ro_prev_q;

  // Next edge count for this cycle. It saturates, and an increment attempted at the ceiling sets the sticky flag.
  always_comb begin
    cnt_step = cnt_q;
    sat_step = sat_q;
    if (rise) begin
      if (cnt_q == CNT_MAX) sat_step = 1'b1;
      else                  cnt_step = cnt_q + COUNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MEASURE;
          win_d   = WIN_LOAD;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      MEASURE: begin
        cnt_d = cnt_step;
        sat_d = sat_step;
        if (win_q == '0) begin
          // The last window cycle's edge is included in the published result.
          count_d = cnt_step;
          ovf_d   = sat_step;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          win_d = win_q - WIN_W'(1);
        end
      end
      HOLD: begin
        if (ready_i) begin
          valid_d = 1'b0;
          if (continuous) begin
            state_d = MEASURE;
            win_d   = WIN_LOAD;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      ro_prev_q <= 1'b0;
      win_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], ro};
      ro_prev_q <= ro_s;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_rip_ro_freq_counter.sv
module tb_rip_ro_freq_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ro;
  logic ready = 1'b1;
  logic continuous = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  logic        busy_a, busy_b, busy_c;
  logic [15:0] count_a, count_c;
  logic [1:0]  count_b;
  logic        ovf_a, ovf_b, ovf_c;
  logic        valid_a, valid_b, valid_c;

  int total = 0;
  int bad   = 0;
  int ro_mode = 0;   // 0: hold low, 1: hold high, N>=2: toggle every N clk cycles
  int lat;

  typedef struct {
    logic [15:0] c;
    logic        o;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // a: W=16, 16-bit count;  b: W=16, 2-bit count (saturates);  c: W=8 for continuous mode
  rip_ro_freq_counter #(.WINDOW_CYCLES(16), .COUNT_W(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .ro(ro), .start(start_a), .continuous(continuous),
    .busy(busy_a), .count_o(count_a), .overflow_o(ovf_a), .valid_o(valid_a), .ready_i(ready));
  rip_ro_freq_counter #(.WINDOW_CYCLES(16), .COUNT_W(2), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .ro(ro), .start(start_b), .continuous(continuous),
    .busy(busy_b), .count_o(count_b), .overflow_o(ovf_b), .valid_o(valid_b), .ready_i(ready));
  rip_ro_freq_counter #(.WINDOW_CYCLES(8), .COUNT_W(16), .SYNC_STAGES(3)) dut_c (
    .clk(clk), .rst(rst), .ro(ro), .start(start_c), .continuous(continuous),
    .busy(busy_c), .count_o(count_c), .overflow_o(ovf_c), .valid_o(valid_c), .ready_i(ready));

  // Oscillator stimulus, changed only on falling clk edges
  initial begin
    int ph;
    ph = 0;
    ro = 1'b0;
    forever begin
      @(negedge clk);
      case (ro_mode)
        0: ro = 1'b0;
        1: ro = 1'b1;
        default: begin
          ph++;
          if (ph >= ro_mode) begin
            ph = 0;
            ro = ~ro;
          end
        end
      endcase
    end
  end

  function automatic logic vld(input int w);
    case (w)
      0: return valid_a;
      1: return valid_b;
      default: return valid_c;
    endcase
  endfunction

  function automatic logic [15:0] cnt(input int w);
    case (w)
      0: return count_a;
      1: return {14'd0, count_b};
      default: return count_c;
    endcase
  endfunction

  function automatic logic ovf(input int w);
    case (w)
      0: return ovf_a;
      1: return ovf_b;
      default: return ovf_c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Waits on falling edges until valid_o is high. lat counts falling edges, starting from base.
  task automatic wait_valid(input int w, input int base, output int l);
    l = base;
    for (int i = 0; i < 200; i++) begin
      if (i > 0 || base >= 0) begin
        @(negedge clk);
        l++;
      end
      if (vld(w)) return;
    end
    total++;
    bad++;
    $error("FAIL timeout dut%0d observed valid=0 after 200 cycles expected valid=1", w);
    l = -1;
  endtask

  // Pops the expected result and compares it with the DUT output currently presented.
  task automatic check_result(input int w, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=unexpected_result expected=empty_scoreboard", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_count"}, {16'd0, cnt(w)}, {16'd0, e.c});
    chk({tag, "_ovf"}, {31'd0, ovf(w)}, {31'd0, e.o});
  endtask

  // Called on a falling edge. Pulses start for one cycle, then returns the start-to-valid latency in cycles.
  task automatic run(input int w, output int l);
    case (w)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    wait_valid(w, 1, l);
  endtask

  initial begin
    // Reset state, seen asynchronously before any clock edge
    #1;
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_count", {16'd0, count_a}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
    wait_cycles(3);
    rst = 1'b0;

    // Oscillator period 4 over a 16-cycle window gives 4 edges
    ro_mode = 2;
    wait_cycles(10);
    sb.push_back('{16'd4, 1'b0});
    run(0, lat);
    chk("t1_latency", lat, 32'd17);
    check_result(0, "t1");
    @(negedge clk);
    chk("t1_valid_drop", {31'd0, valid_a}, 32'd0);
    chk("t1_idle", {31'd0, busy_a}, 32'd0);
    chk("t1_count_kept", {16'd0, count_a}, 32'd4);

    // Static ro, held low and then held high
    ro_mode = 0;
    wait_cycles(10);
    sb.push_back('{16'd0, 1'b0});
    run(0, lat);
    check_result(0, "ro_low");
    ro_mode = 1;
    wait_cycles(10);
    sb.push_back('{16'd0, 1'b0});
    run(0, lat);
    check_result(0, "ro_high");

    // 2-bit counter: 4 edges saturate at 3; the next window clears the flag
    ro_mode = 2;
    wait_cycles(10);
    sb.push_back('{16'd3, 1'b1});
    run(1, lat);
    check_result(1, "sat");
    ro_mode = 4;
    wait_cycles(12);
    sb.push_back('{16'd2, 1'b0});
    run(1, lat);
    check_result(1, "sat_clear");

    // Backpressure: the result holds and start is ignored
    ro_mode = 2;
    wait_cycles(10);
    ready = 1'b0;
    sb.push_back('{16'd4, 1'b0});
    run(0, lat);
    check_result(0, "bp");
    for (int i = 0; i < 10; i++) begin
      start_a = i[0];
      @(negedge clk);
      chk("bp_valid", {31'd0, valid_a}, 32'd1);
      chk("bp_busy", {31'd0, busy_a}, 32'd1);
      chk("bp_count", {16'd0, count_a}, 32'd4);
    end
    start_a = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, valid_a}, 32'd0);
    chk("bp_release_idle", {31'd0, busy_a}, 32'd0);

    // Continuous mode, W=8, period 4: one result every 9 cycles, each count 2
    wait_cycles(4);
    continuous = 1'b1;
    for (int r = 0; r < 4; r++) sb.push_back('{16'd2, 1'b0});
    run(2, lat);
    chk("cont_first_latency", lat, 32'd9);
    check_result(2, "cont0");
    for (int r = 1; r < 4; r++) begin
      if (r == 3) begin
        // The handshake for result 2 happens at the next rising edge. Clear continuous after it, so that result 3 ends the run.
        @(negedge clk);
        continuous = 1'b0;
        wait_valid(2, 1, lat);
      end else begin
        wait_valid(2, 0, lat);
      end
      chk("cont_period", lat, 32'd9);
      check_result(2, "cont");
    end
    @(negedge clk);
    chk("cont_stop_idle", {31'd0, busy_c}, 32'd0);
    chk("cont_stop_valid", {31'd0, valid_c}, 32'd0);

    // Reset in the middle of a measurement
    wait_cycles(4);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_cycles(5);
    #2 rst = 1'b1;
    #1;
    chk("rst_meas_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_meas_count", {16'd0, count_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(10);

    // Reset while a result waits in HOLD
    ready = 1'b0;
    sb.push_back('{16'd4, 1'b0});
    run(0, lat);
    check_result(0, "pre_rst_hold");
    #2 rst = 1'b1;
    #1;
    chk("rst_hold_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_hold_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_hold_count", {16'd0, count_a}, 32'd0);
    chk("rst_hold_ovf", {31'd0, ovf_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    wait_cycles(10);
    sb.push_back('{16'd4, 1'b0});
    run(0, lat);
    chk("post_rst_latency", lat, 32'd17);
    check_result(0, "post_rst");
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
